// File: rtl/mmio_uart_tx_if.sv
// Processor load/store bus as seen by a memory-mapped peripheral.
// The master is the memory stage and the slave is the peripheral.
interface mmio_uart_tx_if #(
  parameter int WIDTH = 32
);
  logic             wr_en;
  logic [WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_addr;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and a pollable STATUS register.
// The register map is TXDATA at BASE_ADDR, STATUS at BASE_ADDR+1 and CTRL at BASE_ADDR+2.
module mmio_uart_tx #(
  parameter int               WIDTH        = 32,
  parameter int               CLKS_PER_BIT = 16,
  parameter int               FIFO_DEPTH   = 8,
  parameter logic [WIDTH-1:0] BASE_ADDR    = WIDTH'('h40000010)
) (
  input  logic                 clk,
  input  logic                 reset,
  mmio_uart_tx_if.slave        bus,
  output logic                 tx,
  output logic                 busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BCNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [WIDTH-1:0]  STATUS_ADDR = BASE_ADDR + WIDTH'(1);
  localparam logic [WIDTH-1:0]  CTRL_ADDR   = BASE_ADDR + WIDTH'(2);
  localparam logic [CNT_W-1:0]  DEPTH_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [BCNT_W-1:0] BCNT_LAST   = BCNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [BCNT_W-1:0] bcnt;
  logic [2:0]        bidx;
  logic [7:0]        shift;
  logic              tx_q;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  logic full;
  logic empty;
  logic push_req;
  logic push_ok;
  logic pop;
  logic flush;
  logic clr_ovf;
  logic set_ovf;
  logic unused_wr_data;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign busy  = (state != IDLE) || !empty;
  assign tx    = tx_q;
  assign unused_wr_data = ^bus.wr_data[WIDTH-1:8];

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    push_req = 1'b0;
    flush    = 1'b0;
    clr_ovf  = 1'b0;
    if (bus.wr_en && bus.wr_addr == BASE_ADDR) push_req = 1'b1;
    if (bus.wr_en && bus.wr_addr == CTRL_ADDR) begin
      flush   = bus.wr_data[1];
      clr_ovf = bus.wr_data[0];
    end
    // A flush empties the FIFO outright, so it also suppresses a pending pop.
    pop     = (state == IDLE) && !empty && !flush;
    push_ok = push_req && !flush && (!full || pop);
    set_ovf = push_req && !flush && full && !pop;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push_ok) - CNT_W'(pop);
      end
      if (set_ovf)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // NOTE: the FIFO storage has no reset; the count and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= bus.wr_data[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rd_data <= '0;
    end else if (bus.rd_en && bus.rd_addr == STATUS_ADDR) begin
      bus.rd_data <= WIDTH'({8'(count), overflow, busy, empty, full});
    end else begin
      bus.rd_data <= '0;
    end
  end

  // tx_q is loaded with the level of the state being entered, so the line follows the FSM with no decode glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      bcnt  <= '0;
      bidx  <= '0;
      shift <= '0;
      tx_q  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift <= fifo_mem[rd_ptr];
            bcnt  <= '0;
            tx_q  <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bcnt == BCNT_LAST) begin
            bcnt  <= '0;
            bidx  <= '0;
            tx_q  <= shift[0];
            state <= DATA;
          end else begin
            bcnt <= bcnt + BCNT_W'(1);
          end
        end
        DATA: begin
          if (bcnt == BCNT_LAST) begin
            bcnt <= '0;
            if (bidx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              shift <= shift >> 1;
              tx_q  <= shift[1];
              bidx  <= bidx + 3'd1;
            end
          end else begin
            bcnt <= bcnt + BCNT_W'(1);
          end
        end
        STOP: begin
          if (bcnt == BCNT_LAST) begin
            bcnt  <= '0;
            state <= IDLE;
          end else begin
            bcnt <= bcnt + BCNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE   = 32'h40000010;
  localparam logic [31:0] STATUS = BASE + 32'd1;
  localparam logic [31:0] CTRL   = BASE + 32'd2;

  logic clk = 1'b0;
  logic reset;
  logic tx;
  logic busy;

  int total = 0;
  int bad   = 0;

  mmio_uart_tx_if #(.WIDTH(32)) bus ();

  mmio_uart_tx #(
    .WIDTH        (32),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4),
    .BASE_ADDR    (BASE)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bus drivers: each starts and ends on a falling edge and spans one rising edge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr;
    @(negedge clk);
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    data = bus.rd_data;
  endtask

  // Entered at offset 2 of a frame (middle of the start bit); returns at offset 39.
  task automatic check_frame(input logic [7:0] b, input string name);
    logic exp_bit;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      exp_bit = 1'b0;
      else if (i == 9) exp_bit = 1'b1;
      else             exp_bit = b[i-1];
      total++;
      if (tx !== exp_bit || busy !== 1'b1) begin
        bad++;
        $display("FAIL %s bit%0d: tx=%b busy=%b want tx=%b busy=1", name, i, tx, busy, exp_bit);
      end
      if (i < 9) repeat (4) @(negedge clk);
    end
    @(negedge clk);
    total++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s last stop cycle: tx=%b busy=%b want tx=1 busy=1", name, tx, busy);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_en = 1'b0; bus.rd_addr = '0;
    repeat (3) @(negedge clk);
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || bus.rd_data !== 32'h0) begin
      bad++;
      $display("FAIL reset outputs: tx=%b busy=%b rd_data=%h want 1 0 0", tx, busy, bus.rd_data);
    end
    reset = 1'b0;
    @(negedge clk);
    bus_read(STATUS, rd);
    total++;
    if (rd !== 32'h2) begin
      bad++;
      $display("FAIL reset status: got %h want 00000002", rd);
    end
  endtask

  task automatic test_single_frame();
    bus_write(BASE, 32'h55);
    total++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single push edge: tx=%b busy=%b want tx=1 busy=1", tx, busy);
    end
    @(negedge clk);
    total++;
    if (tx !== 1'b0) begin
      bad++;
      $display("FAIL single start latency: tx=%b want 0", tx);
    end
    repeat (2) @(negedge clk);
    check_frame(8'h55, "single 0x55");
    @(negedge clk);
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single after stop: tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [7:0]  bytes [3];
    bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
    bus_write(BASE, 32'h41);
    bus_write(BASE, 32'h42);
    bus_write(BASE, 32'h43);
    // The first frame started one falling edge ago; this read ends at its offset 2.
    bus_read(STATUS, rd);
    total++;
    if (rd !== 32'h24) begin
      bad++;
      $display("FAIL b2b status after first pop: got %h want 00000024", rd);
    end
    for (int f = 0; f < 3; f++) begin
      check_frame(bytes[f], $sformatf("b2b frame%0d", f));
      @(negedge clk);
      if (f < 2) begin
        total++;
        if (tx !== 1'b1) begin
          bad++;
          $display("FAIL b2b gap%0d idle cycle: tx=%b want 1", f, tx);
        end
        @(negedge clk);
        total++;
        if (tx !== 1'b0) begin
          bad++;
          $display("FAIL b2b gap%0d next start: tx=%b want 0", f, tx);
        end
        repeat (2) @(negedge clk);
      end else begin
        total++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
          bad++;
          $display("FAIL b2b end: tx=%b busy=%b want tx=1 busy=0", tx, busy);
        end
      end
    end
  endtask

  // Leaves a full FIFO with a frame starting, for test_pop_push_full.
  task automatic test_overflow();
    logic [31:0] rd;
    for (int i = 0; i < 5; i++) bus_write(BASE, 32'h10 + 32'(i));
    bus_write(BASE, 32'hEE);
    bus_read(STATUS, rd);
    total++;
    if (rd !== 32'h4D) begin
      bad++;
      $display("FAIL overflow status: got %h want 0000004d", rd);
    end
    bus_write(CTRL, 32'h1);
    bus_read(STATUS, rd);
    total++;
    if (rd !== 32'h45) begin
      bad++;
      $display("FAIL overflow clear status: got %h want 00000045", rd);
    end
  endtask

  task automatic test_pop_push_full();
    logic [31:0] rd;
    // The 0x10 frame began 7 falling edges before this task; its IDLE pop cycle is 33 edges on.
    repeat (33) @(negedge clk);
    bus_write(BASE, 32'h15);
    total++;
    if (tx !== 1'b0) begin
      bad++;
      $display("FAIL pop+push next start: tx=%b want 0", tx);
    end
    bus_read(STATUS, rd);
    total++;
    if (rd !== 32'h45) begin
      bad++;
      $display("FAIL pop+push full status: got %h want 00000045", rd);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    logic        idle_ok;
    // Currently at offset 1 of the 0x11 frame; offset 18 is mid data bit 3 (a 0).
    repeat (17) @(negedge clk);
    total++;
    if (tx !== 1'b0) begin
      bad++;
      $display("FAIL midreset pre bit3: tx=%b want 0", tx);
    end
    reset = 1'b1;
    #1;
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset immediate: tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    bus_read(STATUS, rd);
    total++;
    if (rd !== 32'h2) begin
      bad++;
      $display("FAIL midreset status: got %h want 00000002", rd);
    end
    idle_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
      @(negedge clk);
    end
    total++;
    if (idle_ok !== 1'b1) begin
      bad++;
      $display("FAIL midreset residual frame: idle_ok=%b want 1", idle_ok);
    end
  endtask

  task automatic test_status_and_flush();
    logic [31:0] rd;
    logic        idle_ok;
    bus.rd_en   = 1'b1;
    bus.rd_addr = STATUS;
    total++;
    if (bus.rd_data !== 32'h0) begin
      bad++;
      $display("FAIL status before edge: got %h want 00000000", bus.rd_data);
    end
    @(negedge clk);
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    total++;
    if (bus.rd_data !== 32'h2) begin
      bad++;
      $display("FAIL status one cycle later: got %h want 00000002", bus.rd_data);
    end
    @(negedge clk);
    total++;
    if (bus.rd_data !== 32'h0) begin
      bad++;
      $display("FAIL status after rd_en low: got %h want 00000000", bus.rd_data);
    end
    bus_read(BASE + 32'd3, rd);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL read base+3: got %h want 00000000", rd);
    end
    bus_write(BASE, 32'hA5);
    bus_write(BASE, 32'h3C);
    bus_write(BASE, 32'h7E);
    bus_write(CTRL, 32'h2);
    check_frame(8'hA5, "flush inflight 0xA5");
    @(negedge clk);
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL flush end: tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
    bus_read(STATUS, rd);
    total++;
    if (rd !== 32'h2) begin
      bad++;
      $display("FAIL flush status: got %h want 00000002", rd);
    end
    idle_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (tx !== 1'b1) idle_ok = 1'b0;
      @(negedge clk);
    end
    total++;
    if (idle_ok !== 1'b1) begin
      bad++;
      $display("FAIL flush leftover frame: idle_ok=%b want 1", idle_ok);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_pop_push_full();
    test_reset_mid_frame();
    test_status_and_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
